// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and ALU operation each state.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    logic       funct_ok;
    logic [2:0] funct_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // Funct decode shared by DECODE (legality) and EXECUTE (ALU op)
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = S_FETCH;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = ALU_ADD;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                // Gated by rst_n so no IR/PC load can slip through during reset
                irwrite = mem_ready & rst_n;
                pcwrite = mem_ready & rst_n;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) state_d = S_EXECUTE;
                        else          illegal = 1'b1;
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEXEC;
                    OP_J:    state_d = S_JUMP;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues the expected
// control vector per cycle, a negedge monitor pops and compares.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       illegal;
    } ctrl_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       iord, irwrite, pcwrite, branch, alusrca;
    logic       memwrite, regwrite, regdst, memtoreg, illegal;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;

    ctrl_t got;
    ctrl_t exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .iord(iord), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got = {state, iord, irwrite, pcwrite, branch, pcsrc, alusrca,
                  alusrcb, alucontrol, memwrite, regwrite, regdst, memtoreg, illegal};

    // Hand-written expected vectors, one per state
    function automatic ctrl_t base(input logic [3:0] st);
        ctrl_t c;
        c = '0;
        c.state = st;
        c.alucontrol = 3'b010;
        return c;
    endfunction
    function automatic ctrl_t e_fetch(input logic mr);
        ctrl_t c;
        c = base(4'd0); c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr;
        return c;
    endfunction
    function automatic ctrl_t e_decode(input logic ill);
        ctrl_t c;
        c = base(4'd1); c.alusrcb = 2'b11; c.illegal = ill;
        return c;
    endfunction
    function automatic ctrl_t e_memadr();
        ctrl_t c;
        c = base(4'd2); c.alusrca = 1'b1; c.alusrcb = 2'b10;
        return c;
    endfunction
    function automatic ctrl_t e_memrd();
        ctrl_t c;
        c = base(4'd3); c.iord = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_memwb();
        ctrl_t c;
        c = base(4'd4); c.regwrite = 1'b1; c.memtoreg = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_memwr();
        ctrl_t c;
        c = base(4'd5); c.iord = 1'b1; c.memwrite = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_exec(input logic [2:0] ac);
        ctrl_t c;
        c = base(4'd6); c.alusrca = 1'b1; c.alusrcb = 2'b00; c.alucontrol = ac;
        return c;
    endfunction
    function automatic ctrl_t e_aluwb();
        ctrl_t c;
        c = base(4'd7); c.regwrite = 1'b1; c.regdst = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_branch();
        ctrl_t c;
        c = base(4'd8); c.alusrca = 1'b1; c.alucontrol = 3'b110;
        c.pcsrc = 2'b01; c.branch = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_addiex();
        ctrl_t c;
        c = base(4'd9); c.alusrca = 1'b1; c.alusrcb = 2'b10;
        return c;
    endfunction
    function automatic ctrl_t e_addiwb();
        ctrl_t c;
        c = base(4'd10); c.regwrite = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t e_jump();
        ctrl_t c;
        c = base(4'd11); c.pcsrc = 2'b10; c.pcwrite = 1'b1;
        return c;
    endfunction

    // Drive one cycle's inputs just after the edge and queue what that cycle must show
    task automatic step(input string nm, input logic rn, input logic mr,
                        input logic [5:0] op, input logic [5:0] fn, input ctrl_t e);
        @(posedge clk);
        #1;
        rst_n = rn; mem_ready = mr; opcode = op; funct = fn;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctrl_t e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h (state got %0d req %0d)",
                         nm, got, e, got.state, e.state);
            end
        end
    end

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    initial begin
        logic [5:0] fn_tab [5];
        logic [2:0] ac_tab [5];
        int wait_cyc;
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ac_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;

        // Reset holds FETCH values; mem_ready high must not leak into irwrite/pcwrite
        step("rst_hold0", 0, 1, RT, 6'h20, e_fetch(0));
        step("rst_hold1", 0, 1, RT, 6'h20, e_fetch(0));
        step("rst_release", 1, 1, LW, 6'h00, e_fetch(1));

        // lw, no stalls: 0,1,2,3,4,0
        step("lw_decode", 1, 0, LW, 6'h00, e_decode(0));
        step("lw_memadr", 1, 0, LW, 6'h00, e_memadr());
        step("lw_memrd", 1, 1, LW, 6'h00, e_memrd());
        step("lw_memwb", 1, 0, LW, 6'h00, e_memwb());

        // Fetch stall, then sw with 3 stall cycles in MEMWR
        step("sw_fetch_stall", 1, 0, SW, 6'h00, e_fetch(0));
        step("sw_fetch", 1, 1, SW, 6'h00, e_fetch(1));
        step("sw_decode", 1, 0, SW, 6'h00, e_decode(0));
        step("sw_memadr", 1, 1, SW, 6'h00, e_memadr());
        step("sw_memwr0", 1, 0, SW, 6'h00, e_memwr());
        step("sw_memwr1", 1, 0, SW, 6'h00, e_memwr());
        step("sw_memwr2", 1, 0, SW, 6'h00, e_memwr());
        step("sw_memwr3", 1, 1, SW, 6'h00, e_memwr());

        // R-type sweep
        for (int i = 0; i < 5; i++) begin
            step("r_fetch", 1, 1, RT, fn_tab[i], e_fetch(1));
            step("r_decode", 1, 0, RT, fn_tab[i], e_decode(0));
            step("r_execute", 1, 0, RT, fn_tab[i], e_exec(ac_tab[i]));
            step("r_aluwb", 1, 0, RT, fn_tab[i], e_aluwb());
        end

        step("addi_fetch", 1, 1, ADDI, 6'h00, e_fetch(1));
        step("addi_decode", 1, 0, ADDI, 6'h00, e_decode(0));
        step("addi_exec", 1, 0, ADDI, 6'h00, e_addiex());
        step("addi_wb", 1, 0, ADDI, 6'h00, e_addiwb());

        step("beq_fetch", 1, 1, BEQ, 6'h00, e_fetch(1));
        step("beq_decode", 1, 0, BEQ, 6'h00, e_decode(0));
        step("beq_branch", 1, 1, BEQ, 6'h00, e_branch());

        step("j_fetch", 1, 1, JMP, 6'h00, e_fetch(1));
        step("j_decode", 1, 0, JMP, 6'h00, e_decode(0));
        step("j_jump", 1, 0, JMP, 6'h00, e_jump());

        // Illegal opcode and illegal R-type funct: one-cycle pulse, back to FETCH
        step("ill_op_fetch", 1, 1, 6'b111111, 6'h00, e_fetch(1));
        step("ill_op_decode", 1, 0, 6'b111111, 6'h00, e_decode(1));
        step("ill_fn_fetch", 1, 1, RT, 6'b000001, e_fetch(1));
        step("ill_fn_decode", 1, 0, RT, 6'b000001, e_decode(1));

        // Reset landing in EXECUTE: must show FETCH before the next clock edge
        step("rx_fetch", 1, 1, RT, 6'b100010, e_fetch(1));
        step("rx_decode", 1, 0, RT, 6'b100010, e_decode(0));
        step("rx_rst_exec", 0, 1, RT, 6'b100010, e_fetch(0));
        step("rx_rst_hold", 0, 1, RT, 6'b100010, e_fetch(0));
        step("rx_release", 1, 1, SW, 6'h00, e_fetch(1));

        // Reset during a stalled store drops memwrite at once
        step("rw_decode", 1, 0, SW, 6'h00, e_decode(0));
        step("rw_memadr", 1, 0, SW, 6'h00, e_memadr());
        step("rw_memwr", 1, 0, SW, 6'h00, e_memwr());
        step("rw_rst", 0, 0, SW, 6'h00, e_fetch(0));
        step("rw_release", 1, 0, SW, 6'h00, e_fetch(0));

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state sequencer for the multicycle MIPS datapath: one shared ALU, one unified instruction/data memory, and instruction/data registers between stages. It walks each instruction through fetch, decode, execute, memory and writeback states. In every state it drives the datapath mux selects, the register/memory write enables and the ALU operation. It supports lw, sw, beq, addi, j and R-type add/sub/and/or/slt, and waits on a memory ready handshake.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the instruction register; stable from DECODE until return to FETCH
- funct  in  6  instruction[5:0]; same stability rule as opcode
- mem_ready  in  1  memory completes the current read/write this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  load instruction register
- pcwrite  out  1  unconditional PC load
- branch  out  1  conditional PC load; the datapath ANDs it with ALU zero
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  write-back data select: 0 = ALUOut, 1 = data register
- illegal  out  1  one-cycle pulse when an unsupported opcode or funct is decoded
- state  out  4  current state encoding, for debug

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Encodings 12–15 are unreachable; if entered, the next state is FETCH.
- Every output not listed for a state is 0. alucontrol is 010 unless stated.
- FETCH: alusrcb = 01, pcsrc = 00. irwrite and pcwrite equal mem_ready (Mealy). Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: alusrcb = 11 (branch target precomputed into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) with funct in {100000, 100010, 100100, 100101, 101010} → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 000010 (j) → JUMP
  - anything else, including R-type with another funct → FETCH, with illegal = 1 for this cycle
- MEMADR: alusrca = 1, alusrcb = 10. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1. Hold until mem_ready = 1, then go to MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, regdst = 0. Next is FETCH.
- MEMWR: iord = 1, memwrite = 1, held for every cycle in this state. Hold until mem_ready = 1, then go to FETCH.
- EXECUTE: alusrca = 1, alusrcb = 00. alucontrol from funct: add 010, sub 110, and 000, or 001, slt 111. Next is ALUWB.
- ALUWB: regwrite = 1, regdst = 1, memtoreg = 0. Next is FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, alucontrol = 110, pcsrc = 01, branch = 1. Next is FETCH.
- ADDIEXEC: alusrca = 1, alusrcb = 10. Next is ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0. Next is FETCH.
- JUMP: pcsrc = 10, pcwrite = 1. Next is FETCH.
- pcwrite and branch are never both 1. irwrite is only ever 1 in FETCH.

## Timing
- The state register updates on the rising edge of clk. All outputs are combinational from the state register; irwrite/pcwrite in FETCH also depend on mem_ready.
- Reset: rst_n low forces state = FETCH immediately, without waiting for a clock edge. While rst_n is low, irwrite and pcwrite are 0. Other outputs hold their FETCH values: alusrcb = 01, alucontrol = 010, pcsrc = 00, all else 0, state = 0. The first fetch can complete on the first rising edge after rst_n goes high with mem_ready = 1.
- Reset mid-instruction (any state) discards the instruction. A pending memwrite drops in the same cycle rst_n falls.
- Cycle counts with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

## Test plan
- Reset: assert rst_n low mid-EXECUTE → state = 0 immediately; irwrite = pcwrite = 0; alusrcb = 01 while low. Release with mem_ready = 1 → irwrite = pcwrite = 1 in the first cycle.
- lw with mem_ready high: opcode 100011 → states 0,1,2,3,4,0. In state 4: regwrite = 1, memtoreg = 1, regdst = 0.
- sw with memory stall: opcode 101011, mem_ready low for 3 cycles in MEMWR → memwrite = 1 for 4 cycles, iord = 1 throughout, then state = 0.
- R-type sweep: each of funct 100000/100010/100100/100101/101010 → alucontrol 010/110/000/001/111 in EXECUTE, then regwrite = 1 and regdst = 1 in ALUWB.
- beq and j: opcode 000100 → BRANCH with branch = 1, pcsrc = 01, alucontrol = 110, pcwrite = 0. Opcode 000010 → JUMP with pcwrite = 1, pcsrc = 10.
- Illegal: opcode 111111, and opcode 000000 with funct 000001 → illegal = 1 for exactly one cycle in DECODE, next state = 0, no regwrite or memwrite asserted.
